// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardwired zero, post-reset clear and a0 debug tap.
// Latency: 1 cycle read (registered dout), a0 follows post-write value 1 cycle after the write edge.
// Backpressure: none; writes are dropped and outputs held at 0 while init_busy is high.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wr_en/wr_addr/din  single write port (ignored while clearing)
//   rd_addr / dout     NUM_RD packed read indices / packed registered read data
//   init_busy          high while the clear sequencer walks the array
//   a0                 registered mirror of entry DBG_ADDR
//
// Optional feature macro: REGFILE_BYPASS_EN (write-first forwarding on read/write collision;
// read-first when undefined).
module reg_file_mp #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_RD        = 2,
  parameter int ZERO_REG      = 1,
  parameter int DBG_ADDR      = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [ADDRESS_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]    dout,
  output logic                            init_busy,
  output logic [DATA_WIDTH-1:0]           a0
);

  localparam int AW    = ADDRESS_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DBG_IDX  = AW'(DBG_ADDR);
  localparam bit ZERO_EN = (ZERO_REG != 0);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            run;
  logic [AW-1:0]   clr_ptr;
  logic [DW-1:0]   mem [DEPTH];
  logic            wr_drop;
  logic            wr_fire;
  logic [DW-1:0]   rd_val [NUM_RD];
  logic [DW-1:0]   a0_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  // Next-state logic: leave INIT on the edge that clears the last entry
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (clr_ptr == LAST_IDX) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  // Output decode
  always_comb begin
    init_busy = (state == S_INIT);
    run       = (state == S_RUN);
  end

  // Clear pointer walks every entry once per INIT pass
  always_ff @(posedge clk) begin
    if (rst)       clr_ptr <= '0;
    else if (!run) clr_ptr <= clr_ptr + 1'b1;
  end

  // Writes to x0 are discarded when it is hardwired; such writes are also never forwarded
  always_comb begin
    wr_drop = ZERO_EN && (wr_addr == '0);
    wr_fire = run && wr_en && !wr_drop;
  end

  // Storage: no reset on the array itself, it is cleared by the sequencer instead
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run)         mem[clr_ptr] <= '0;
      else if (wr_fire) mem[wr_addr] <= din;
    end
  end

  // Per-port read mux; zero-register override is applied last so it wins over forwarding
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_val[k] = mem[rd_addr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      if (wr_fire && (rd_addr[k*AW +: AW] == wr_addr)) rd_val[k] = din;
`endif
      if (ZERO_EN && (rd_addr[k*AW +: AW] == '0)) rd_val[k] = '0;
    end
  end

  // a0 always shows the post-write value so a write is visible after one edge, not two
  always_comb begin
    a0_nxt = mem[DBG_IDX];
    if (wr_fire && (wr_addr == DBG_IDX)) a0_nxt = din;
    if (ZERO_EN && (DBG_IDX == '0))      a0_nxt = '0;
  end

  // Registered outputs, held at 0 through reset and the clear pass
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      dout <= '0;
      a0   <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) dout[k*DW +: DW] <= rd_val[k];
      a0 <= a0_nxt;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised + directed bench for reg_file_mp at default parameters.
// Latency: checks outputs 1 time unit after each rising edge against a behavioural model.
// Backpressure: n/a.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] din;
  logic [9:0]  rd_addr;
  logic [63:0] dout;
  logic        init_busy;
  logic [31:0] a0;

  reg_file_mp dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .din       (din),
    .rd_addr   (rd_addr),
    .dout      (dout),
    .init_busy (init_busy),
    .a0        (a0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: register contents plus number of clear cycles still owed
  logic [31:0] mdl [32];
  int          left  = 0;
  logic        known = 1'b0;

  int          n;
  logic [4:0]  r_wa, r_ra0, r_ra1;
  logic        r_rst, r_we;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] ra, input logic we,
                                             input logic [4:0] wa, input logic [31:0] d);
    if (ra == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == ra && wa != 5'd0) return d;
`endif
    return mdl[ra];
  endfunction

  // Apply one clock of stimulus, predict, and compare after the edge
  task automatic cycle(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] d, input logic [4:0] ra0, input logic [4:0] ra1);
    logic [31:0] e0, e1, ea;
    logic        eb;
    rst = r; wr_en = we; wr_addr = wa; din = d; rd_addr = {ra1, ra0};
    if (r) begin
      e0 = 0; e1 = 0; ea = 0; eb = 1'b1; left = 32; known = 1'b1;
    end else if (left > 0) begin
      mdl[32 - left] = 32'd0;
      left--;
      e0 = 0; e1 = 0; ea = 0; eb = (left > 0);
    end else begin
      e0 = model_read(ra0, we, wa, d);
      e1 = model_read(ra1, we, wa, d);
      if (we && wa != 5'd0) mdl[wa] = d;
      ea = mdl[10];
      eb = 1'b0;
    end
    @(posedge clk);
    #1;
    if (known) begin
      chk_eq("dout0", {32'd0, dout[31:0]}, {32'd0, e0});
      chk_eq("dout1", {32'd0, dout[63:32]}, {32'd0, e1});
      chk_eq("a0", {32'd0, a0}, {32'd0, ea});
      chk_eq("init_busy", {63'd0, init_busy}, {63'd0, eb});
    end
  endtask

  function automatic logic [4:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd7;
      2:       return 5'd10;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; din = '0; rd_addr = '0;

    // Reset for two cycles, then count the clear pass; a write inside it must be ignored
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(0, (i == 3), 5'd5, 32'hAA, 5'd5, 5'd5);
      n++;
      if (!init_busy) break;
    end
    chk_eq("init_len", 64'(n), 64'd32);

    for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 5'(i), 5'(31 - i));
    cycle(0, 0, 0, 0, 5'd5, 5'd5);
    chk_eq("init_write_ignored", {32'd0, dout[31:0]}, 64'd0);

    // Basic write then read on both ports
    cycle(0, 1, 5'd3, 32'hDEADBEEF, 5'd0, 5'd0);
    cycle(0, 0, 0, 0, 5'd3, 5'd3);
    chk_eq("x3_p0", {32'd0, dout[31:0]}, 64'hDEADBEEF);
    chk_eq("x3_p1", {32'd0, dout[63:32]}, 64'hDEADBEEF);

    // Zero register: same-cycle and later reads of x0
    cycle(0, 1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    chk_eq("x0_same_cycle", {32'd0, dout[31:0]}, 64'd0);
    cycle(0, 0, 0, 0, 5'd0, 5'd0);
    chk_eq("x0_read", {32'd0, dout[31:0]}, 64'd0);

    // Read/write collision on x7
    cycle(0, 1, 5'd7, 32'h11, 5'd0, 5'd0);
    cycle(0, 1, 5'd7, 32'h22, 5'd7, 5'd0);
`ifdef REGFILE_BYPASS_EN
    chk_eq("collide", {32'd0, dout[31:0]}, 64'h22);
`else
    chk_eq("collide", {32'd0, dout[31:0]}, 64'h11);
`endif
    cycle(0, 0, 0, 0, 5'd7, 5'd0);
    chk_eq("collide_next", {32'd0, dout[31:0]}, 64'h22);

    // a0 tap
    cycle(0, 1, 5'd10, 32'hCAFE, 5'd0, 5'd0);
    chk_eq("a0_write", {32'd0, a0}, 64'hCAFE);
    cycle(0, 1, 5'd11, 32'hBEEF, 5'd0, 5'd0);
    chk_eq("a0_other", {32'd0, a0}, 64'hCAFE);

    // Fill with garbage, x10=5, then reset in RUN
    for (int i = 1; i < 32; i++) cycle(0, 1, 5'(i), $urandom, 5'(i), 5'd0);
    cycle(0, 1, 5'd10, 32'd5, 5'd0, 5'd0);
    chk_eq("a0_five", {32'd0, a0}, 64'd5);
    cycle(1, 0, 0, 0, 0, 0);
    chk_eq("a0_rst", {32'd0, a0}, 64'd0);
    cycle(1, 0, 0, 0, 0, 0);

    // Reset again at INIT cycle 15; clear must restart and take a full 32 cycles
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      n++;
      if (!init_busy) break;
    end
    chk_eq("init_len_restart", 64'(n), 64'd32);
    for (int i = 0; i < 32; i++) cycle(0, 0, 0, 0, 5'(i), 5'(31 - i));
    cycle(0, 0, 0, 0, 5'd10, 5'd10);
    chk_eq("x10_cleared", {32'd0, dout[31:0]}, 64'd0);

    // Randomised traffic biased toward x0, x7, x10 and collisions
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_we  = ($urandom_range(0, 1) == 1);
      r_wa  = pick_addr();
      r_ra0 = ($urandom_range(0, 1) == 1) ? r_wa : pick_addr();
      r_ra1 = ($urandom_range(0, 1) == 1) ? r_wa : pick_addr();
      cycle(r_rst, r_we, r_wa, $urandom, r_ra0, r_ra1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the team's 2-read/1-write register file. Configurable read-port count, width and depth.
- Hardwired-zero register, a post-reset clear sequencer, and a registered debug tap (a0) on a selectable register.
- Sits in the decode stage of the RISC-V core; feeds operand latches and the top-level a0 output.

Parameters:
- ADDRESS_WIDTH, 5, register index width; depth = 2**ADDRESS_WIDTH entries.
- DATA_WIDTH, 32, register width in bits.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1, entry 0 is hardwired to zero; when 0, entry 0 is an ordinary register.
- DBG_ADDR, 10, index of the register mirrored on a0 (10 = RISC-V a0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDRESS_WIDTH  write index.
- din  in  DATA_WIDTH  write data.
- rd_addr  in  NUM_RD*ADDRESS_WIDTH  packed read indices; port k uses bits [k*AW +: AW].
- dout  out  NUM_RD*DATA_WIDTH  packed registered read data; port k uses bits [k*DW +: DW].
- init_busy  out  1  high while the clear sequencer runs; the file is unusable while high.
- a0  out  DATA_WIDTH  registered copy of entry DBG_ADDR.

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset (rst=1 at an edge):
  - dout all 0, a0=0, init_busy=1.
  - Clear pointer set to 0; FSM enters INIT.
  - Array contents are not touched by reset itself.
- FSM states: INIT and RUN.
- INIT:
  - Each cycle with rst=0, write 0 to entry[ptr] and increment ptr.
  - When ptr = 2**AW-1 has been cleared, the next state is RUN and init_busy drops to 0 on that same edge.
  - INIT lasts exactly 2**AW cycles after rst deasserts (32 at default).
  - wr_en is ignored in INIT.
  - dout and a0 are held at 0 throughout INIT.
- RUN:
  - Stays in RUN until rst; rst in any state returns to INIT with ptr=0.
  - rst asserted mid-INIT restarts the clear from entry 0.
- Read latency is 1 cycle: dout[k] at edge n+1 reflects rd_addr[k] sampled at edge n.
- Ports are independent. Any combination of equal addresses across ports and the write port is legal.
- Write: when wr_en=1 in RUN, entry[wr_addr] <= din at the edge.
  - If ZERO_REG=1 and wr_addr=0, the write is discarded.
- Zero register: if ZERO_REG=1, any read of index 0 returns 0, regardless of array contents.
- Same-cycle read/write collision (rd_addr[k] = wr_addr, wr_en=1) is governed by the optional feature below.
- a0: in RUN, a0 <= post-write value of entry DBG_ADDR every cycle.
  - A write to DBG_ADDR at edge n appears on a0 after edge n (1-cycle latency, not 2).
  - If ZERO_REG=1 and DBG_ADDR=0, a0 is constant 0.
- No width conversion: din and dout are DATA_WIDTH, with no sign or zero extension.

Optional Feature:
- REGFILE_BYPASS_EN defined:
  - On a collision with a non-discarded write, dout[k] returns din (write-first), per port independently.
  - A discarded write to x0 is never forwarded; x0 still reads 0.
- Undefined:
  - On a collision, dout[k] returns the old entry value (read-first).
  - The new value is visible on the next read.

Test Plan:
- Reset/clear: preload garbage, rst=1 for 2 cycles then 0.
  - init_busy stays high for exactly 32 cycles after deassert.
  - Afterwards, a read of every index on both ports returns 0.
  - wr_en=1, wr_addr=5, din=0xAA issued during INIT is ignored; reading 5 returns 0.
- Basic write/read: write x3=0xDEADBEEF, then read port0=3 and port1=3 -> both dout=0xDEADBEEF one cycle later.
- Zero register: write x0=0x12345678, then read 0 -> 0.
  - With the macro, a same-cycle read of 0 during that write also returns 0.
- Collision: x7 holds 0x11; write x7=0x22 with rd_addr[0]=7 in the same cycle.
  - Bypass build: dout0=0x22.
  - Non-bypass build: dout0=0x11, then 0x22 on the next read.
- a0 tap: write x10=0xCAFE at edge n -> a0=0xCAFE after edge n.
  - A write to x11 leaves a0 unchanged.
- Reset mid-operation: rst pulsed at INIT cycle 15 -> clear restarts and init_busy lasts a further 32 cycles.
  - rst pulsed in RUN with x10=5 -> a0=0 immediately after the edge, and x10 reads 0 after INIT completes.
